// File: rtl/seq_det_pkg.sv
// Shared constants for the programmable sequence detector: default pattern,
// seven-segment glyphs (active-low, segment a in the MSB) and a width helper.
package seq_det_pkg;

  localparam int unsigned DEF_LEN     = 9;
  localparam logic [8:0]  DEF_PATTERN = 9'b101100100;

  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  // Bits needed to hold a length value in 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_seg7.sv
// Registered seven-segment decoder for the detector's progress value.
// Values above 9 are shown as a dash.
module seg7_decoder
  import seq_det_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] value,
  output logic [6:0] segments
);

  logic [6:0] seg_next;

  always_comb begin
    seg_next = SEG_DASH;
    case (value)
      5'd0: seg_next = SEG_0;
      5'd1: seg_next = SEG_1;
      5'd2: seg_next = SEG_2;
      5'd3: seg_next = SEG_3;
      5'd4: seg_next = SEG_4;
      5'd5: seg_next = SEG_5;
      5'd6: seg_next = SEG_6;
      5'd7: seg_next = SEG_7;
      5'd8: seg_next = SEG_8;
      5'd9: seg_next = SEG_9;
      default: seg_next = SEG_DASH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) segments <= SEG_0;
    else       segments <= seg_next;
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control, saturating
// match counter and prefix progress. Define SEQ_DET_SEG7_EN to add LED_out.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned          MAX_LEN         = 9,
  parameter int unsigned          CNT_W           = 8,
  parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = MAX_LEN'(DEF_PATTERN),
  parameter int unsigned          DEFAULT_LEN     = DEF_LEN
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        sequence_in,
  input  logic                        in_valid,
  input  logic                        overlap_en,
  input  logic                        pattern_load,
  input  logic [MAX_LEN-1:0]          pattern_data,
  input  logic [len_w(MAX_LEN)-1:0]   pattern_len,
  input  logic                        clear_count,
  output logic                        match,
  output logic [CNT_W-1:0]            match_count,
  output logic [len_w(MAX_LEN)-1:0]   progress
`ifdef SEQ_DET_SEG7_EN
  ,
  output logic [6:0]                  LED_out
`endif
);

  localparam int unsigned LW = len_w(MAX_LEN);
  typedef logic [LW-1:0] len_t;

  logic [MAX_LEN-1:0] pattern;
  len_t               len;
  // The oldest history bit is never compared again, so only MAX_LEN-1 bits are kept.
  logic [MAX_LEN-2:0] history;
  len_t               fill;

  logic               accept;
  logic [MAX_LEN-1:0] hist_next;
  len_t               fill_inc;
  len_t               load_len;
  logic [MAX_LEN:1]   prefix_ok;
  len_t               progress_next;
  logic               hit;

  assign accept    = in_valid && !pattern_load;
  assign hist_next = {history, sequence_in};
  assign fill_inc  = (fill == len_t'(MAX_LEN)) ? fill : fill + len_t'(1);
  assign load_len  = (pattern_len == '0 || pattern_len > len_t'(MAX_LEN))
                     ? len_t'(MAX_LEN) : pattern_len;

  // prefix_ok[k]: newest k bits equal the first k pattern bits (pattern[len-1 -: k]).
  for (genvar k = 1; k <= MAX_LEN; k++) begin : g_prefix
    localparam logic [MAX_LEN-1:0] MASK = {MAX_LEN{1'b1}} >> (MAX_LEN - k);
    assign prefix_ok[k] = (len_t'(k) <= len) && (len_t'(k) <= fill_inc)
                          && ((((pattern >> (len - len_t'(k))) ^ hist_next) & MASK) == '0);
  end

  always_comb begin
    progress_next = '0;
    for (int unsigned k = 1; k <= MAX_LEN; k++) begin
      if (prefix_ok[k]) progress_next = len_t'(k);
    end
  end

  assign hit = (progress_next == len);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pattern  <= DEFAULT_PATTERN;
      len      <= len_t'(DEFAULT_LEN);
      history  <= '0;
      fill     <= '0;
      progress <= '0;
      match    <= 1'b0;
    end else begin
      match <= 1'b0;
      if (pattern_load) begin
        pattern  <= pattern_data;
        len      <= load_len;
        history  <= '0;
        fill     <= '0;
        progress <= '0;
      end else if (in_valid) begin
        history  <= hist_next[MAX_LEN-2:0];
        fill     <= (hit && !overlap_en) ? '0 : fill_inc;
        progress <= progress_next;
        match    <= hit;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      match_count <= '0;
    end else if (clear_count) begin
      match_count <= '0;
    end else if (accept && hit && match_count != '1) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

`ifdef SEQ_DET_SEG7_EN
  seg7_decoder u_seg7 (
    .clock    (clock),
    .reset    (reset),
    .value    (5'(progress)),
    .segments (LED_out)
  );
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: vector table plus hand sequences for
// counter saturation and mid-sequence reset. LED_out checked under SEQ_DET_SEG7_EN.
module tb_seq_detector_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       sequence_in, in_valid, overlap_en, pattern_load, clear_count;
  logic [8:0] pattern_data;
  logic [3:0] pattern_len;
  logic       match, match2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic [3:0] progress, progress2;
`ifdef SEQ_DET_SEG7_EN
  logic [6:0] led, led2;
`endif

  int passed = 0;
  int total  = 0;
  int prog_now = 0;
  logic [8:0] dp = 9'b101100100;

  always #5 clock = ~clock;

  seq_detector_param dut (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
    .overlap_en(overlap_en), .pattern_load(pattern_load), .pattern_data(pattern_data),
    .pattern_len(pattern_len), .clear_count(clear_count), .match(match),
    .match_count(match_count), .progress(progress)
`ifdef SEQ_DET_SEG7_EN
    , .LED_out(led)
`endif
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
    .overlap_en(overlap_en), .pattern_load(pattern_load), .pattern_data(pattern_data),
    .pattern_len(pattern_len), .clear_count(clear_count), .match(match2),
    .match_count(match_count2), .progress(progress2)
`ifdef SEQ_DET_SEG7_EN
    , .LED_out(led2)
`endif
  );

  typedef struct {
    logic       v, b, ld, ov, clr;
    logic [8:0] pd;
    logic [3:0] pl;
    logic       em;
    int         ep, ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t bit_v(logic b, logic ov, logic em, int ep, int ec);
    vec_t r = '{v:1'b1, b:b, ld:1'b0, ov:ov, clr:1'b0, pd:9'd0, pl:4'd0, em:em, ep:ep, ec:ec};
    return r;
  endfunction

  function automatic vec_t gap_v(logic b, int ep, int ec);
    vec_t r = '{v:1'b0, b:b, ld:1'b0, ov:1'b1, clr:1'b0, pd:9'd0, pl:4'd0, em:1'b0, ep:ep, ec:ec};
    return r;
  endfunction

  function automatic vec_t load_v(logic [8:0] pd, logic [3:0] pl, logic v, logic b, int ec);
    vec_t r = '{v:v, b:b, ld:1'b1, ov:1'b1, clr:1'b0, pd:pd, pl:pl, em:1'b0, ep:0, ec:ec};
    return r;
  endfunction

  function automatic vec_t clr_v(int ep);
    vec_t r = '{v:1'b0, b:1'b0, ld:1'b0, ov:1'b1, clr:1'b1, pd:9'd0, pl:4'd0, em:1'b0, ep:ep, ec:0};
    return r;
  endfunction

  function automatic int seg_of(int p);
    case (p)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111110;
    endcase
  endfunction

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic em, input int ep, input int ec);
    check({tag, " match"}, match, em);
    check({tag, " match2"}, match2, em);
    check({tag, " progress"}, progress, ep);
    check({tag, " progress2"}, progress2, ep);
    check({tag, " count"}, match_count, ec);
`ifdef SEQ_DET_SEG7_EN
    check({tag, " led"}, led, seg_of(prog_now));
    check({tag, " led2"}, led2, seg_of(prog_now));
`endif
    prog_now = ep;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " match"}, match, 0);
    check({tag, " progress"}, progress, 0);
    check({tag, " count"}, match_count, 0);
    check({tag, " count2"}, match_count2, 0);
`ifdef SEQ_DET_SEG7_EN
    check({tag, " led"}, led, seg_of(0));
`endif
    prog_now = 0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    in_valid     = v.v;
    sequence_in  = v.b;
    pattern_load = v.ld;
    overlap_en   = v.ov;
    clear_count  = v.clr;
    pattern_data = v.pd;
    pattern_len  = v.pl;
    tick();
    check_outputs(tag, v.em, v.ep, v.ec);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sequence_in = 1'b0; in_valid = 1'b0; overlap_en = 1'b1;
    pattern_load = 1'b0; clear_count = 1'b0; pattern_data = '0; pattern_len = '0;
    #12;
    check_reset("reset");
    @(negedge clock);
    reset = 1'b0;

    // Default pattern, overlap on, then a gap cycle
    for (int i = 8; i >= 1; i--) vecs.push_back(bit_v(dp[i], 1'b1, 1'b0, 9 - i, 0));
    vecs.push_back(bit_v(dp[0], 1'b1, 1'b1, 9, 1));
    vecs.push_back(gap_v(1'b1, 9, 1));
    // 101 overlapping
    vecs.push_back(load_v(9'b101, 4'd3, 1'b0, 1'b0, 1));
    vecs.push_back(bit_v(1'b1, 1'b1, 1'b0, 1, 1));
    vecs.push_back(bit_v(1'b0, 1'b1, 1'b0, 2, 1));
    vecs.push_back(bit_v(1'b1, 1'b1, 1'b1, 3, 2));
    vecs.push_back(bit_v(1'b0, 1'b1, 1'b0, 2, 2));
    vecs.push_back(bit_v(1'b1, 1'b1, 1'b1, 3, 3));
    // 101 non-overlapping
    vecs.push_back(load_v(9'b101, 4'd3, 1'b0, 1'b0, 3));
    vecs.push_back(bit_v(1'b1, 1'b0, 1'b0, 1, 3));
    vecs.push_back(bit_v(1'b0, 1'b0, 1'b0, 2, 3));
    vecs.push_back(bit_v(1'b1, 1'b0, 1'b1, 3, 4));
    vecs.push_back(bit_v(1'b0, 1'b0, 1'b0, 0, 4));
    vecs.push_back(bit_v(1'b1, 1'b0, 1'b0, 1, 4));
    // 101 overlapping with gaps between accepted bits
    vecs.push_back(load_v(9'b101, 4'd3, 1'b0, 1'b0, 4));
    vecs.push_back(bit_v(1'b1, 1'b1, 1'b0, 1, 4));
    vecs.push_back(gap_v(1'b0, 1, 4));
    vecs.push_back(bit_v(1'b0, 1'b1, 1'b0, 2, 4));
    vecs.push_back(gap_v(1'b1, 2, 4));
    vecs.push_back(bit_v(1'b1, 1'b1, 1'b1, 3, 5));
    vecs.push_back(gap_v(1'b0, 3, 5));
    vecs.push_back(bit_v(1'b0, 1'b1, 1'b0, 2, 5));
    vecs.push_back(gap_v(1'b0, 2, 5));
    vecs.push_back(bit_v(1'b1, 1'b1, 1'b1, 3, 6));
    vecs.push_back(gap_v(1'b1, 3, 6));
    // Load collides with the completing bit; new pattern 11 takes over
    vecs.push_back(load_v(9'b101, 4'd3, 1'b0, 1'b0, 6));
    vecs.push_back(bit_v(1'b1, 1'b1, 1'b0, 1, 6));
    vecs.push_back(bit_v(1'b0, 1'b1, 1'b0, 2, 6));
    vecs.push_back(load_v(9'b011, 4'd2, 1'b1, 1'b1, 6));
    vecs.push_back(bit_v(1'b1, 1'b1, 1'b0, 1, 6));
    vecs.push_back(bit_v(1'b1, 1'b1, 1'b1, 2, 7));
    // Length clamping: 0 and 12 both become 9
    vecs.push_back(load_v(dp, 4'd0, 1'b0, 1'b0, 7));
    vecs.push_back(bit_v(1'b1, 1'b1, 1'b0, 1, 7));
    vecs.push_back(bit_v(1'b0, 1'b1, 1'b0, 2, 7));
    vecs.push_back(bit_v(1'b1, 1'b1, 1'b0, 3, 7));
    vecs.push_back(load_v(dp, 4'd12, 1'b0, 1'b0, 7));
    vecs.push_back(bit_v(1'b1, 1'b1, 1'b0, 1, 7));
    vecs.push_back(bit_v(1'b0, 1'b1, 1'b0, 2, 7));
    vecs.push_back(clr_v(2));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Saturation on the 2-bit counter, then clear concurrent with a match
    apply(load_v(9'b1, 4'd1, 1'b0, 1'b0, 0), "sat_load");
    for (int i = 0; i < 6; i++) begin
      apply(bit_v(1'b1, 1'b0, 1'b1, 1, i + 1), $sformatf("sat%0d", i));
      check($sformatf("sat%0d count2", i), match_count2, (i + 1 > 3) ? 3 : i + 1);
    end
    clear_count = 1'b1; in_valid = 1'b1; sequence_in = 1'b1;
    tick();
    check_outputs("clr_hit", 1'b1, 1, 0);
    check("clr_hit count2", match_count2, 0);
    apply(bit_v(1'b1, 1'b0, 1'b1, 1, 1), "post_clr");
    check("post_clr count2", match_count2, 1);
    apply(bit_v(1'b0, 1'b0, 1'b0, 0, 1), "post_clr_zero");

    // Reset after five bits of the default sequence
    apply(load_v(dp, 4'd9, 1'b0, 1'b0, 1), "rst_load");
    for (int i = 8; i >= 4; i--) apply(bit_v(dp[i], 1'b1, 1'b0, 9 - i, 1), $sformatf("pre_rst%0d", i));
    #2 reset = 1'b1;
    #1 check_reset("async_rst");
    in_valid = 1'b1; sequence_in = 1'b1;
    tick();
    check_reset("held_rst");
    @(negedge clock);
    reset = 1'b0;
    apply(bit_v(1'b0, 1'b1, 1'b0, 0, 0), "tail0");
    apply(bit_v(1'b1, 1'b1, 1'b0, 1, 0), "tail1");
    apply(bit_v(1'b0, 1'b1, 1'b0, 2, 0), "tail2");
    apply(bit_v(1'b0, 1'b1, 1'b0, 0, 0), "tail3");
    for (int i = 8; i >= 1; i--) apply(bit_v(dp[i], 1'b1, 1'b0, 9 - i, 0), $sformatf("redo%0d", i));
    apply(bit_v(dp[0], 1'b1, 1'b1, 9, 1), "redo_match");
    in_valid = 1'b0;
    tick();
    check_outputs("redo_idle", 1'b0, 9, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Runtime-programmable serial bit-pattern detector, successor to the fixed 9-bit Moore detectors in the FPGA demo set.
- Pattern length (1..MAX_LEN) and bit pattern are loadable; overlapping or non-overlapping detection is selectable.
- Outputs a registered match pulse, a saturating match counter and a match-progress value.
- Optional seven-segment display of progress.

Parameters:
- MAX_LEN, 9, maximum pattern length in bits (2..16).
- CNT_W, 8, width of the match counter.
- DEFAULT_PATTERN, 9'b101100100, pattern after reset, MAX_LEN bits wide; right-aligned.
- DEFAULT_LEN, 9, pattern length after reset.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- sequence_in  in  1  serial data bit.
- in_valid  in  1  sequence_in is sampled only when high.
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping.
- pattern_load  in  1  loads pattern_data/pattern_len.
- pattern_data  in  MAX_LEN  new pattern, right-aligned.
- pattern_len  in  $clog2(MAX_LEN+1)  new length.
- clear_count  in  1  synchronous clear of match_count.
- match  out  1  one-cycle pulse per detected match.
- match_count  out  CNT_W  saturating count of matches.
- progress  out  $clog2(MAX_LEN+1)  matched-prefix length.
- LED_out  out  7  seven-segment, active-low (only with SEG7_EN).

Behaviour:
- Reset (async, any time, including mid-sequence) sets:
  - pattern=DEFAULT_PATTERN, len=DEFAULT_LEN;
  - history=0, fill=0, match=0, match_count=0, progress=0;
  - LED_out=7'b0000001.
- Bit order: pattern bit [len-1] is the first bit expected on the line; bit [0] is the last.
- Accepted bit (in_valid=1, pattern_load=0):
  - history <= {history, sequence_in}, newest bit at [0];
  - fill <= min(fill+1, MAX_LEN).
- Match condition: fill_next >= len and history_next[len-1:0] == pattern[len-1:0].
- Latency: match is registered and asserts the cycle after the completing bit is sampled. It is high for exactly one cycle per match and never asserts without an accepted bit.
- progress (registered, same cycle as match) = largest k in 0..len with k <= fill_next and the newest k history bits equal pattern[len-1 : len-k]. Equals len on a match cycle.
- Non-overlap mode: on a match, fill is forced to 0 in the same update, so the next match needs len fresh bits. Overlap mode leaves fill untouched.
- overlap_en is sampled per accepted bit; changing it mid-stream affects only subsequent bits.
- match_count increments on each match and saturates at 2^CNT_W-1. clear_count wins over a simultaneous increment (result 0).
- pattern_load:
  - latches pattern_data and pattern_len, clears history/fill/progress, does not alter match_count;
  - has priority over in_valid, so a bit arriving in the same cycle is discarded and no match occurs;
  - pattern_len of 0 or above MAX_LEN is clamped to MAX_LEN.
- in_valid=0: all state holds; match=0.
- len=1: every accepted bit equal to pattern[0] is a match. Non-overlap mode behaves identically at len=1.

Optional Feature:
- SEQ_DET_SEG7_EN defined:
  - LED_out drives a registered decode of progress, one cycle after progress;
  - digits 0..9 use active-low abcdefg with a as MSB ("0"=7'b0000001, "1"=7'b1001111, "9"=7'b0000100);
  - values 10..16 show 7'b1111110 (dash).
- Undefined: LED_out port absent; no decode logic.

Decomposition:
- Package seq_det_pkg: seven-segment digit constants (SEG_0..SEG_9, SEG_DASH), default pattern/length constants, width helper function.
- One sub-module, seg7_decoder (registered, 5-bit in, 7-bit out), instantiated only under SEQ_DET_SEG7_EN.
- Prefix/progress computation stays inline as a generate loop.

Test Plan:
- Default after reset, stream 1,0,1,1,0,0,1,0,0 with in_valid=1: match=1 exactly one cycle after the 9th bit, match_count=1, progress=9; LED_out=7'b0000100 with SEG7_EN.
- Load pattern 3'b101, len=3, stream 1,0,1,0,1:
  - overlap_en=1 gives matches after bits 3 and 5, count=2;
  - overlap_en=0 gives a single match after bit 3, count=1.
- Same stream with in_valid gaps (0 between every bit): identical match timing relative to accepted bits; match never asserts in gap cycles.
- CNT_W=2, pattern len=1 "1", stream of six 1s: count reaches 3 and holds. clear_count concurrent with a match gives count=0.
- Assert reset after the first 5 bits of the default sequence, then send the remaining 4: no match, progress reflects only post-reset bits, all outputs at reset values during reset.
- pattern_load in the same cycle as the final completing bit: no match, history cleared, new pattern active on the next cycle.
